// File: rtl/alu_pkg.sv
// Shared constants and the issue-entry type for the ALU issue stage.
package alu_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_NOR   = 4'b0101;
  localparam logic [3:0] ALU_SLT   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_PASSA = 4'b1011;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef struct packed {
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [3:0]  ALU_control;
  } issue_entry_t;

endpackage

// File: rtl/alu_issue_fifo.sv
// DEPTH-entry issue FIFO (power-of-two DEPTH >= 2); flush clears occupancy.
module alu_issue_fifo
  import alu_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = issue_entry_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_flush,
  input  logic i_push,
  input  T     i_data,
  output logic o_ready,
  input  logic i_pop,
  output logic o_valid,
  output T     o_data
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;

  assign o_ready = (r_cnt < CW'(DEPTH));
  assign o_valid = (r_cnt != '0);
  assign o_data  = r_mem[r_rptr];
  assign w_push  = i_push & o_ready;
  assign w_pop   = i_pop & o_valid;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes R/I-type ops into buffered ALU entries.
// Optional illegal-op counter port enabled by ALU_ISSUE_ERRCNT_EN.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [15:0] immediate,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] operandA,
  output logic [31:0] operandB,
  output logic [3:0]  ALU_control,
  output logic        illegal_op
`ifdef ALU_ISSUE_ERRCNT_EN
  ,
  output logic [7:0]  illegal_cnt
`endif
);
  issue_entry_t w_ent, w_head;
  logic         w_illegal, w_accept, w_fifo_rdy;
  logic         r_init, r_illegal;
  logic [31:0]  w_simm, w_zimm;

  assign w_simm = {{16{immediate[15]}}, immediate};
  assign w_zimm = {16'b0, immediate};

  always_comb begin
    w_ent     = '0;
    w_illegal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        w_ent.operandA = rs_data;
        w_ent.operandB = rt_data;
        case (funct)
          F_ADD, F_ADDU: w_ent.ALU_control = ALU_ADD;
          F_SUB, F_SUBU: w_ent.ALU_control = ALU_SUB;
          F_AND:         w_ent.ALU_control = ALU_AND;
          F_OR:          w_ent.ALU_control = ALU_OR;
          F_XOR:         w_ent.ALU_control = ALU_XOR;
          F_NOR:         w_ent.ALU_control = ALU_NOR;
          F_SLT:         w_ent.ALU_control = ALU_SLT;
          F_SLTU:        w_ent.ALU_control = ALU_SLTU;
          F_SLL, F_SRL, F_SRA: begin
            w_ent.operandA    = rt_data;
            w_ent.operandB    = {27'b0, shamt};
            w_ent.ALU_control = (funct == F_SLL) ? ALU_SLL :
                                (funct == F_SRL) ? ALU_SRL : ALU_SRA;
          end
          F_SLLV, F_SRLV, F_SRAV: begin
            w_ent.operandA    = rt_data;
            w_ent.operandB    = rs_data;
            w_ent.ALU_control = (funct == F_SLLV) ? ALU_SLL :
                                (funct == F_SRLV) ? ALU_SRL : ALU_SRA;
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_ADDIU: w_ent = '{rs_data, w_simm, ALU_ADD};
      OP_SLTI:           w_ent = '{rs_data, w_simm, ALU_SLT};
      OP_SLTIU:          w_ent = '{rs_data, w_simm, ALU_SLTU};
      OP_ANDI:           w_ent = '{rs_data, w_zimm, ALU_AND};
      OP_ORI:            w_ent = '{rs_data, w_zimm, ALU_OR};
      OP_XORI:           w_ent = '{rs_data, w_zimm, ALU_XOR};
      OP_LUI:            w_ent = '{{immediate, 16'b0}, 32'b0, ALU_PASSA};
      default:           w_illegal = 1'b1;
    endcase
  end

  // in_ready stays low through reset and rises on the first edge after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_init    <= 1'b1;
      r_illegal <= w_accept & w_illegal & ~flush;
    end
  end

  assign in_ready   = r_init & w_fifo_rdy;
  assign w_accept   = in_valid & in_ready;
  assign illegal_op = r_illegal;

  alu_issue_fifo #(.DEPTH(DEPTH), .T(issue_entry_t)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_accept & ~w_illegal),
    .i_data  (w_ent),
    .o_ready (w_fifo_rdy),
    .i_pop   (out_ready),
    .o_valid (out_valid),
    .o_data  (w_head)
  );

  assign operandA    = out_valid ? w_head.operandA    : 32'b0;
  assign operandB    = out_valid ? w_head.operandB    : 32'b0;
  assign ALU_control = out_valid ? w_head.ALU_control : 4'b0;

`ifdef ALU_ISSUE_ERRCNT_EN
  logic [7:0] r_ill_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_ill_cnt <= '0;
    else if (r_illegal && r_ill_cnt != 8'hFF) r_ill_cnt <= r_ill_cnt + 8'd1;
  end
  assign illegal_cnt = r_ill_cnt;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; drives and samples on the falling edge.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, illegal_op;
  logic [5:0]  opcode, funct;
  logic [4:0]  shamt;
  logic [15:0] immediate;
  logic [31:0] rs_data, rt_data, operandA, operandB;
  logic [3:0]  ALU_control;
`ifdef ALU_ISSUE_ERRCNT_EN
  logic [7:0]  illegal_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .shamt(shamt), .immediate(immediate),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .operandA(operandA), .operandB(operandB), .ALU_control(ALU_control),
    .illegal_op(illegal_op)
`ifdef ALU_ISSUE_ERRCNT_EN
    , .illegal_cnt(illegal_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drv(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                     input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
    opcode = op; funct = fn; shamt = sh; immediate = imm; rs_data = rs; rt_data = rt;
  endtask

  // One-cycle accept; on return the entry is visible at the head.
  task automatic send(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                      input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
    drv(op, fn, sh, imm, rs, rt);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic head(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    chk({tag, ".vld"}, {31'b0, out_valid}, 32'd1);
    chk({tag, ".A"}, operandA, a);
    chk({tag, ".B"}, operandB, b);
    chk({tag, ".ctl"}, {28'b0, ALU_control}, {28'b0, c});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drv(6'h00, 6'h00, 5'd0, 16'h0, 32'h0, 32'h0);
    #2;
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst.illegal", {31'b0, illegal_op}, 32'd0);
    chk("rst.opA", operandA, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel.in_ready_low", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    chk("rel.in_ready_high", {31'b0, in_ready}, 32'd1);

    // Decode vectors, out_ready=1
    send(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd5, 32'd0);
    head("addi", 32'd5, 32'hFFFF_FFFF, 4'b0000);
    @(negedge clk);
    chk("drain.out_valid", {31'b0, out_valid}, 32'd0);
    chk("drain.opB_zero", operandB, 32'd0);
    send(6'h0D, 6'h00, 5'd0, 16'h8000, 32'h0F0F_0000, 32'd0);
    head("ori", 32'h0F0F_0000, 32'h0000_8000, 4'b0011);
    send(6'h0F, 6'h00, 5'd0, 16'h1234, 32'hDEAD_BEEF, 32'd0);
    head("lui", 32'h1234_0000, 32'd0, 4'b1011);
    send(6'h00, 6'h03, 5'd7, 16'h0, 32'h55, 32'h8000_0000);
    head("sra", 32'h8000_0000, 32'd7, 4'b1010);
    send(6'h00, 6'h23, 5'd0, 16'h0, 32'h10, 32'h3);
    head("subu", 32'h10, 32'h3, 4'b0001);
    send(6'h00, 6'h07, 5'd0, 16'h0, 32'h4, 32'hF000_0000);
    head("srav", 32'hF000_0000, 32'h4, 4'b1010);
    send(6'h0A, 6'h00, 5'd0, 16'h8001, 32'h9, 32'd0);
    head("slti", 32'h9, 32'hFFFF_8001, 4'b0110);
    send(6'h0C, 6'h00, 5'd0, 16'h8001, 32'h9, 32'd0);
    head("andi", 32'h9, 32'h0000_8001, 4'b0010);
    @(negedge clk);

    // Backpressure: 3 pushes into a 2-deep buffer
    out_ready = 1'b0;
    drv(6'h08, 6'h00, 5'd0, 16'h0, 32'hA, 32'd0);
    in_valid = 1'b1;
    @(negedge clk);
    chk("bp.rdy1", {31'b0, in_ready}, 32'd1);
    chk("bp.headA1", operandA, 32'hA);
    rs_data = 32'hB;
    @(negedge clk);
    chk("bp.full", {31'b0, in_ready}, 32'd0);
    chk("bp.headA2", operandA, 32'hA);
    rs_data = 32'hC;
    @(negedge clk);
    chk("bp.held", {31'b0, in_ready}, 32'd0);
    chk("bp.stable", operandA, 32'hA);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp.headB", operandA, 32'hB);
    chk("bp.rdy2", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp.headC", operandA, 32'hC);
    @(negedge clk);
    chk("bp.empty", {31'b0, out_valid}, 32'd0);

    // Illegal ops
    send(6'h3F, 6'h00, 5'd0, 16'h0, 32'h1, 32'h2);
    chk("ill.pulse", {31'b0, illegal_op}, 32'd1);
    chk("ill.no_vld", {31'b0, out_valid}, 32'd0);
`ifdef ALU_ISSUE_ERRCNT_EN
    @(negedge clk);
    chk("ill.cnt1", {24'b0, illegal_cnt}, 32'd1);
`else
    @(negedge clk);
`endif
    chk("ill.pulse_end", {31'b0, illegal_op}, 32'd0);
    send(6'h00, 6'h3F, 5'd0, 16'h0, 32'h1, 32'h2);
    chk("ill.rfunct", {31'b0, illegal_op}, 32'd1);
    chk("ill.rfunct_vld", {31'b0, out_valid}, 32'd0);
    drv(6'h3F, 6'h00, 5'd0, 16'h0, 32'h0, 32'h0);
    in_valid = 1'b1;
    repeat (300) @(negedge clk);
    in_valid = 1'b0;
    chk("ill.stream", {31'b0, illegal_op}, 32'd1);
    @(negedge clk);
`ifdef ALU_ISSUE_ERRCNT_EN
    chk("ill.sat", {24'b0, illegal_cnt}, 32'd255);
`endif

    // Flush a full buffer
    out_ready = 1'b0;
    drv(6'h08, 6'h00, 5'd0, 16'h1, 32'h77, 32'd0);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    chk("fl.full", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl.vld", {31'b0, out_valid}, 32'd0);
    chk("fl.rdy", {31'b0, in_ready}, 32'd1);
    chk("fl.opA", operandA, 32'd0);
    flush = 1'b1;
    send(6'h3F, 6'h00, 5'd0, 16'h0, 32'h0, 32'h0);
    flush = 1'b0;
    chk("fl.ill_supp", {31'b0, illegal_op}, 32'd0);
    flush = 1'b1;
    send(6'h08, 6'h00, 5'd0, 16'h1, 32'h5, 32'd0);
    flush = 1'b0;
    chk("fl.push_drop", {31'b0, out_valid}, 32'd0);

    // Reset mid-stream
    send(6'h08, 6'h00, 5'd0, 16'h1, 32'h99, 32'd0);
    chk("mr.pre", {31'b0, out_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr.vld", {31'b0, out_valid}, 32'd0);
    chk("mr.rdy", {31'b0, in_ready}, 32'd0);
    chk("mr.opA", operandA, 32'd0);
    chk("mr.opB", operandB, 32'd0);
    chk("mr.ctl", {28'b0, ALU_control}, 32'd0);
`ifdef ALU_ISSUE_ERRCNT_EN
    chk("mr.cnt", {24'b0, illegal_cnt}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("mr.after_vld", {31'b0, out_valid}, 32'd0);
    chk("mr.after_rdy", {31'b0, in_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
